// File: rtl/imem_pkg.sv
// Shared constants and loader state encoding for the instruction memory path.
package imem_pkg;

   // Default instruction memory depth in words.
   localparam int IMEM_DEPTH = 32;

   // Halt instruction encoding; terminates a program image.
   localparam logic [31:0] HALT_WORD = 32'hB4221820;

   // Loader FSM states.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      WRITE = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } loader_state_e;

endpackage

// File: rtl/byte_word_assembler.sv
// Shifts bytes into a 32-bit word, first byte ending up in [31:24].
// word_ready_o flags the shift that completes the fourth byte of a word.
module byte_word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        shift_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_ready_o
);

   logic [31:0] asm_q, asm_d;
   logic [1:0]  cnt_q, cnt_d;

   // Next-state for the shift register and byte counter.
   always_comb begin
      asm_d = asm_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         asm_d = 32'd0;
         cnt_d = 2'd0;
      end else if (shift_i) begin
         asm_d = {asm_q[23:0], byte_i};
         cnt_d = cnt_q + 2'd1;
      end
   end

   // Register update with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         asm_q <= 32'd0;
         cnt_q <= 2'd0;
      end else begin
         asm_q <= asm_d;
         cnt_q <= cnt_d;
      end
   end

   assign word_o       = asm_q;
   assign word_ready_o = shift_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams a big-endian byte image into instruction memory and holds the
// core in reset until the halt word has been written.
// Handshake: a byte transfers on a posedge where byte_valid && byte_ready;
// byte_data is only sampled on that edge and byte_valid may drop at any time.
module imem_loader
   import imem_pkg::*;
#(
   parameter int          DEPTH     = IMEM_DEPTH,
   parameter logic [31:0] HALT_WORD = imem_pkg::HALT_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        mem_we,
   output logic [31:0] mem_waddr,
   output logic [31:0] mem_wdata,
   output logic        cpu_hold,
   output logic        done,
   output logic        error
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

   loader_state_e state_q, state_d;
   logic [AW-1:0] word_cnt_q, word_cnt_d;
   logic [31:0]   waddr_hold_q, wdata_hold_q;
   logic [31:0]   asm_word;
   logic [31:0]   cur_waddr;
   logic          word_ready;
   logic          asm_clear;
   logic          shift_en;

   assign shift_en  = byte_valid && byte_ready;
   assign cur_waddr = {{(30 - AW){1'b0}}, word_cnt_q, 2'b00};

   byte_word_assembler u_asm (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (asm_clear),
      .shift_i      (shift_en),
      .byte_i       (byte_data),
      .word_o       (asm_word),
      .word_ready_o (word_ready)
   );

   // Next-state and Moore outputs of the load sequencer.
   always_comb begin
      state_d    = state_q;
      word_cnt_d = word_cnt_q;
      asm_clear  = 1'b0;
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      cpu_hold   = 1'b1;
      done       = 1'b0;
      error      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RECV;
               word_cnt_d = '0;
               asm_clear  = 1'b1;
            end
         end
         RECV: begin
            byte_ready = 1'b1;
            if (word_ready) state_d = WRITE;
         end
         WRITE: begin
            mem_we = 1'b1;
            if (asm_word == HALT_WORD) begin
               state_d = DONE;
            end else if (word_cnt_q == LAST_WORD) begin
               state_d = ERR;
            end else begin
               word_cnt_d = word_cnt_q + 1'b1;
               state_d    = RECV;
            end
         end
         DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start) begin
               state_d    = RECV;
               word_cnt_d = '0;
               asm_clear  = 1'b1;
            end
         end
         ERR: begin
            error = 1'b1;
            if (start) begin
               state_d    = RECV;
               word_cnt_d = '0;
               asm_clear  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, word counter and held write-port values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         word_cnt_q   <= '0;
         waddr_hold_q <= 32'd0;
         wdata_hold_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         word_cnt_q <= word_cnt_d;
         if (state_q == WRITE) begin
            waddr_hold_q <= cur_waddr;
            wdata_hold_q <= asm_word;
         end
      end
   end

   // Address/data are live during WRITE and keep their last value otherwise.
   assign mem_waddr = (state_q == WRITE) ? cur_waddr : waddr_hold_q;
   assign mem_wdata = (state_q == WRITE) ? asm_word  : wdata_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader (DEPTH=4).
module tb_imem_loader;

   localparam int          DEPTH = 4;
   localparam logic [31:0] HALT  = 32'hB4221820;

   logic        clk;
   logic        reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_q[$];
   logic [31:0] prog[8];

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // scoreboard: every write pulse must match the head of the expected queue
   always @(negedge clk) begin
      if (reset && mem_we) begin
         check_eq("ready_low_in_write", {63'd0, byte_ready}, 64'd0);
         if (exp_q.size() == 0) begin
            check_eq("unexpected_write", {mem_waddr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            check_eq("write_addr_data", {mem_waddr, mem_wdata}, exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_outs"},
               {25'd0, byte_ready, mem_we, cpu_hold, done, error, 2'b00},
               {25'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00});
      check_eq({tag, "_addr_data"}, {mem_waddr, mem_wdata}, 64'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // driver: offer one byte, with random idle gaps, until accepted
   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      bit accepted = 0;
      while ($urandom_range(99) < gap_pct) begin
         byte_valid = 1'b0;
         byte_data  = 8'($urandom);
         tick();
      end
      byte_valid = 1'b1;
      byte_data  = b;
      for (int t = 0; t < 50 && !accepted; t++) begin
         if (byte_ready) accepted = 1;
         tick();
      end
      byte_valid = 1'b0;
      if (!accepted) check_eq("byte_accept_timeout", 64'd0, 64'd1);
   endtask

   // Loads prog[0..n-1]; the model decides which words are written and how the load ends.
   task automatic run_program(input int n, input int gap_pct, input int mid_start);
      int  n_wr = 0;
      bit  halted = 0;
      pulse_start();
      check_eq("start_state", {61'd0, byte_ready, cpu_hold, done | error}, {61'd0, 1'b1, 1'b1, 1'b0});
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({32'(i * 4), prog[i]});
         n_wr++;
         if (prog[i] == HALT) begin
            halted = 1;
            break;
         end
         if (i == DEPTH - 1) break;
      end
      for (int i = 0; i < n_wr; i++) begin
         for (int k = 0; k < 4; k++) begin
            send_byte(prog[i][31 - 8 * k -: 8], gap_pct);
            if (k == 0 && i == mid_start) begin
               pulse_start();
            end
         end
         check_eq("we_after_4th_byte", {63'd0, mem_we}, 64'd1);
      end
      tick();
      check_eq("end_flags", {60'd0, done, error, cpu_hold, byte_ready},
               {60'd0, halted, !halted, !halted, 1'b0});
      check_eq("writes_drained", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      tick();
      check_reset_outputs("reset");
      reset = 1'b1;
      tick();
      check_reset_outputs("idle");

      // basic load, no gaps
      prog[0] = 32'h00004020; prog[1] = 32'h2009000A; prog[2] = HALT;
      run_program(3, 0, -1);

      // same image with random gaps
      run_program(3, 50, -1);

      // overflow: four non-halt words fill the memory
      for (int i = 0; i < 4; i++) prog[i] = 32'h1000_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
      run_program(4, 30, -1);
      byte_valid = 1'b1;
      byte_data  = 8'hAA;
      for (int t = 0; t < 8; t++) tick();
      byte_valid = 1'b0;
      check_eq("no_accept_in_err", {62'd0, byte_ready, error}, {62'd0, 1'b0, 1'b1});

      // halt in the last slot
      for (int i = 0; i < 3; i++) prog[i] = 32'($urandom) & 32'h7FFF_FFFF;
      prog[3] = HALT;
      run_program(4, 20, -1);

      // reset after six bytes of a load
      prog[0] = 32'hCAFE_0001; prog[1] = 32'h1234_5678;
      pulse_start();
      exp_q.push_back({32'd0, prog[0]});
      for (int k = 0; k < 4; k++) send_byte(prog[0][31 - 8 * k -: 8], 0);
      for (int k = 0; k < 2; k++) send_byte(prog[1][31 - 8 * k -: 8], 0);
      check_eq("pre_reset_data", {32'd0, mem_wdata}, {32'd0, prog[0]});
      reset = 1'b0;
      tick();
      check_reset_outputs("midload_reset");
      reset = 1'b1;
      tick();
      exp_q.delete();
      prog[0] = 32'h00004020; prog[1] = 32'h2009000A; prog[2] = HALT;
      run_program(3, 10, -1);

      // start ignored mid-word in RECV, and start in DONE restarts from 0
      prog[0] = 32'h0000_0011; prog[1] = 32'h0000_0022; prog[2] = 32'h0000_0033; prog[3] = HALT;
      run_program(4, 0, 2);

      // random programs, each ending in a halt or a full memory
      for (int r = 0; r < 6; r++) begin
         int len = $urandom_range(1, 4);
         for (int i = 0; i < len; i++) prog[i] = $urandom;
         if (len < 4 || $urandom_range(1) == 1) prog[len - 1] = HALT;
         run_program(len, $urandom_range(0, 60), (r % 2 == 0) ? $urandom_range(0, len - 1) : -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into instruction memory at sequential word-aligned byte addresses, starting at 0.
- Holds the core in reset until the halt word has been written, then releases it.

Parameters:
- DEPTH, 32, instruction memory depth in words; must match the memory's size parameter.
- HALT_WORD, 32'hB4221820, halt instruction encoding; marks end of program.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a new load.
- byte_valid  in  1  byte_data is valid.
- byte_data  in  8  program byte; stream is big-endian, first byte lands in [31:24].
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write enable; one-cycle pulse per word.
- mem_waddr  out  32  byte address, word-aligned; memory indexes with address>>2.
- mem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  keeps the core and PC held; 1 while not loaded.
- done  out  1  halt word written, program loaded.
- error  out  1  memory filled without a halt word.

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE; word_cnt=0; byte_cnt=0; assembly register=0.
  - byte_ready=0, mem_we=0, mem_waddr=0, mem_wdata=0, cpu_hold=1, done=0, error=0.
  - Reset mid-load aborts immediately. Words already written stay in memory; the loader never clears memory.
- Handshake: a byte transfers on a posedge with byte_valid && byte_ready. byte_data is sampled only on transfer.
- State IDLE:
  - Outputs: byte_ready=0, cpu_hold=1.
  - start -> RECV, with word_cnt=0, byte_cnt=0.
- State RECV:
  - Outputs: byte_ready=1.
  - Each transfer does asm = {asm[23:0], byte_data} and increments byte_cnt.
  - The transfer with byte_cnt==3 -> WRITE, with byte_cnt reset to 0.
  - Gaps (byte_valid=0) are allowed indefinitely.
- State WRITE (exactly one cycle):
  - Outputs: byte_ready=0, mem_we=1, mem_waddr=word_cnt<<2, mem_wdata=asm.
  - mem_we asserts on the cycle immediately after the 4th byte is accepted.
  - Next state, in priority order:
    - asm==HALT_WORD -> DONE.
    - Else word_cnt==DEPTH-1 -> ERR.
    - Else word_cnt++ and -> RECV.
  - Peak throughput: one word per 5 cycles.
- State DONE:
  - Outputs: done=1, cpu_hold=0, byte_ready=0.
  - Deasserts on the cycle after the halt write.
- State ERR:
  - Outputs: error=1, cpu_hold=1, byte_ready=0.
- Restart: start in DONE or ERR -> RECV. It clears done and error, reasserts cpu_hold, and resets word_cnt and byte_cnt.
- start in RECV or WRITE is ignored.
- A halt word written at word DEPTH-1 -> DONE, not ERR.
- mem_waddr and mem_wdata hold their last values when mem_we=0.
- word_cnt width is clog2(DEPTH); mem_waddr is zero-extended to 32 bits.
- mem_we is never asserted outside WRITE.

Decomposition:
- Shared package imem_pkg holds:
  - HALT_WORD constant (also used by the decode/halt logic).
  - IMEM_DEPTH default.
  - Loader state encoding IDLE/RECV/WRITE/DONE/ERR.
- One natural sub-module, byte_word_assembler:
  - 4-byte shift register plus 2-bit counter.
  - Interface: shift enable, word_ready flag, clear.
- The FSM, address counter and flags stay in imem_loader.

Test Plan:
- Basic load: after reset, start, then bytes 00 00 40 20 | 20 09 00 0A | B4 22 18 20.
  - Expect mem_we pulses at addresses 0, 4, 8 with data 32'h00004020, 32'h2009000A, 32'hB4221820.
  - done=1 and cpu_hold=0 on the cycle after the 3rd write.
- Backpressure and gaps: byte_valid toggles randomly.
  - Identical writes to the basic load.
  - No byte is lost or duplicated.
  - byte_ready=0 during every WRITE cycle.
- Overflow with DEPTH=4: send 4 non-halt words.
  - Expect 4 writes at addresses 0..12.
  - Then error=1, cpu_hold=1, byte_ready=0.
  - A 5th word is not accepted.
- Halt at last slot with DEPTH=4: 3 words then HALT_WORD.
  - Write at address 12, then done=1, error=0.
- Reset mid-load: reset=0 after 6 bytes.
  - All outputs return to reset values next cycle.
  - A new start reloads from address 0.
- Start handling: a start pulse during RECV has no effect on word_cnt.
  - A start in DONE clears done, sets cpu_hold=1 and restarts at address 0.
